// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through FIFO.
//
// Ports
//   sysclk      in   single rising-edge clock
//   reset       in   synchronous, active-high reset
//   uart_rx     in   asynchronous serial line, idle high
//   rd_en       in   pop FIFO head (ignored while empty)
//   rd_data     out  FIFO head, valid while empty=0 (0 when empty)
//   empty/full  out  FIFO status
//   count       out  number of stored entries
//   frame_err   out  1-cycle pulse, stop bit sampled low
//   parity_err  out  1-cycle pulse, parity mismatch
//   overrun     out  1-cycle pulse, good byte dropped on a full FIFO
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | line idle, waiting for a falling edge
// S_START   | checking the start bit at mid-bit (false-start reject)
// S_DATA    | shifting in DATA_BITS, LSB first
// S_PARITY  | sampling the parity bit
// S_STOP    | sampling the stop bit, push or flag an error
// S_WAIT_IDLE | line held low after a framing error, wait for high

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DCW = $clog2(DIV + 1);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic           PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic rx_meta, rx_s, rx_prev;
    logic start_edge;
    logic [DCW-1:0] div_cnt;
    logic [TW-1:0]  tick_cnt;
    logic tick, sample;
    logic [DATA_BITS-1:0] shift_q;
    logic [BW-1:0] bit_cnt;
    logic parity_bad;
    logic push_c, ferr_c, perr_c;
    logic push_q;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt_q;
    logic wr_fire, rd_fire, ovr_c;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = rx_prev & ~rx_s & (state_q == S_IDLE);

    // Divider and tick counter realign on every accepted start edge so the
    // mid-bit sample point tracks this frame's own start bit.
    always_ff @(posedge sysclk) begin
        if (reset || start_edge) begin
            div_cnt  <= DIV_LAST;
            tick_cnt <= '0;
        end else if (div_cnt == '0) begin
            div_cnt  <= DIV_LAST;
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        end else begin
            div_cnt <= div_cnt - DCW'(1);
        end
    end

    assign tick   = (div_cnt == '0);
    assign sample = tick && (tick_cnt == TICK_MID);

    always_ff @(posedge sysclk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        ferr_c  = 1'b0;
        perr_c  = 1'b0;
        case (state_q)
            S_IDLE:      if (start_edge) state_d = S_START;
            S_START:     if (sample) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (sample && bit_cnt == '0)
                             state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (sample) state_d = S_STOP;
            S_STOP: begin
                if (sample) begin
                    // Framing error takes priority over a parity mismatch.
                    if (!rx_s) begin
                        ferr_c  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else if (parity_bad) begin
                        perr_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        push_c  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            parity_bad <= 1'b0;
        end else begin
            if (state_q == S_START) begin
                bit_cnt    <= BIT_LAST;
                parity_bad <= 1'b0;
            end
            if (state_q == S_DATA && sample) begin
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt - BW'(1);
            end
            if (state_q == S_PARITY && sample)
                parity_bad <= (^shift_q) ^ rx_s ^ PAR_ODD;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            push_q     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            push_q     <= push_c;
            frame_err  <= ferr_c;
            parity_err <= perr_c;
        end
    end

    // A push on a full FIFO still lands when the head is popped in the same cycle.
    assign wr_fire = push_q & (~full | rd_en);
    assign rd_fire = rd_en & ~empty;
    assign ovr_c   = push_q & full & ~rd_en;

    always_ff @(posedge sysclk) begin
        if (wr_fire) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            overrun <= ovr_c;
        end
    end

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign count   = cnt_q;
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule
